bank_biu_linefill: RTL and testbench

- Bank-side memory read engine for cache linefills; feeds the ISU linefill buffer.
- Accepts linefill requests (line address, set, way) and issues one 2-beat read burst per line on the memory AR channel, tagged with ID {set,way}.
- Assembles the two 128-bit R beats into a 256-bit line.
- Delivers each line to the ISU as a single-cycle valid/ready transfer on the biu_isu_* interface, with rid = {set,way}.

---
 rtl/bank_biu_linefill.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_bank_biu_linefill.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_biu_linefill.sv
// ---------------------------------------------------------------------------
// bank_biu_linefill
//   Bank-side memory read engine for cache linefills. Linefill requests are
//   queued, issued as 2-beat AR bursts tagged {set,way}, the two 128-bit R
//   beats are assembled into one 256-bit line, and each line is handed to the
//   ISU linefill buffer as a single valid/ready transfer.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   lf_req_*                linefill request (addr / set / way), valid/ready
//   mem_ar*                 memory read-address channel (len 1, size 16B)
//   mem_r*                  memory read-data channel (rlast/rresp checked only
//                           when the checker is built in)
//   biu_isu_r*              assembled line to ISU, data = {beat1,beat0}
//   outstanding_cnt_o       bursts issued on AR and not yet delivered to ISU
//   err_o                   sticky protocol error
//
// Optional build macro
//   BANK_BIU_LINEFILL_CHK_EN  adds an in-flight ID scoreboard and drives err_o;
//                             without it err_o is tied low.
// ---------------------------------------------------------------------------
module bank_biu_linefill #(
  parameter int unsigned REQ_FIFO_DEPTH  = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   lf_req_valid_i,
  output logic                                   lf_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                  lf_req_addr_i,
  input  logic [2:0]                             lf_req_set_i,
  input  logic [2:0]                             lf_req_way_i,
  output logic                                   mem_arvalid_o,
  input  logic                                   mem_arready_i,
  output logic [ADDR_WIDTH-1:0]                  mem_araddr_o,
  output logic [5:0]                             mem_arid_o,
  output logic [7:0]                             mem_arlen_o,
  output logic [2:0]                             mem_arsize_o,
  input  logic                                   mem_rvalid_i,
  output logic                                   mem_rready_o,
  input  logic [127:0]                           mem_rdata_i,
  input  logic [5:0]                             mem_rid_i,
  input  logic                                   mem_rlast_i,
  input  logic [1:0]                             mem_rresp_i,
  output logic                                   biu_isu_rvalid_o,
  input  logic                                   biu_isu_rready_i,
  output logic [255:0]                           biu_isu_rdata_o,
  output logic [5:0]                             biu_isu_rid_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt_o,
  output logic                                   err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int unsigned LA_W  = ADDR_WIDTH - 5;
  localparam int unsigned ENT_W = LA_W + 6;

  // S_IDLE exists only so mem_rready_o can come out of reset low; it always
  // moves to S_BEAT0 on the first clock after reset.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_OUT
  } state_e;

  // -------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_q [REQ_FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_d [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fcnt_q, fcnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             req_push;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [ENT_W-1:0] req_ent;
  logic [ENT_W-1:0] head_ent;

  // -------------------------------------------------------------------------
  // AR stage and outstanding counter
  // -------------------------------------------------------------------------
  logic             ar_valid_q, ar_valid_d;
  logic [LA_W-1:0]  ar_addr_q, ar_addr_d;
  logic [5:0]       ar_id_q, ar_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ar_hs;
  logic             ar_slot_free;
  logic             ar_credit;
  logic             ar_load;

  // -------------------------------------------------------------------------
  // Assembly FSM and line buffer
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [127:0]     lo_q, lo_d;
  logic [127:0]     hi_q, hi_d;
  logic [5:0]       rid_q, rid_d;
  logic             beat;
  logic             isu_hs;

  assign fifo_full      = (fcnt_q == (PTR_W+1)'(REQ_FIFO_DEPTH));
  assign fifo_empty     = (fcnt_q == '0);
  assign lf_req_ready_o = ~fifo_full;
  assign req_push       = lf_req_valid_i & lf_req_ready_o;
  assign req_ent        = {lf_req_addr_i[ADDR_WIDTH-1:5], lf_req_set_i, lf_req_way_i};

  // An empty FIFO is bypassed so a request can reach AR the cycle after push.
  assign head_ent       = fifo_empty ? req_ent : fifo_q[rd_ptr_q];

  assign ar_hs          = ar_valid_q & mem_arready_i;
  assign ar_slot_free   = ~ar_valid_q | mem_arready_i;

  // The request sitting in the AR register is already committed, so it is
  // counted against the limit; otherwise the counter could pass the maximum
  // once that request handshakes.
  assign ar_credit      = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, ar_valid_q})
                          < (CNT_W+1)'(MAX_OUTSTANDING);
  assign ar_load        = (~fifo_empty | req_push) & ar_slot_free & ar_credit;

  assign fifo_wr        = req_push & ~(ar_load & fifo_empty);
  assign fifo_rd        = ar_load & ~fifo_empty;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (fifo_wr) begin
      fifo_d[wr_ptr_q] = req_ent;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_wr, fifo_rd})
      2'b10:   fcnt_d = fcnt_q + (PTR_W+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PTR_W+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < REQ_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    if (ar_load) begin
      ar_valid_d           = 1'b1;
      {ar_addr_d, ar_id_d} = head_ent;
    end else if (ar_hs) begin
      ar_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && !isu_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!ar_hs && isu_hs) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      cnt_q      <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_arvalid_o     = ar_valid_q;
  assign mem_araddr_o      = {ar_addr_q, 5'b0};
  assign mem_arid_o        = ar_id_q;
  assign mem_arlen_o       = 8'd1;
  assign mem_arsize_o      = 3'd4;
  assign outstanding_cnt_o = cnt_q;

  // -------------------------------------------------------------------------
  // Assembly FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_BEAT0;
      S_BEAT0: if (beat) state_d = S_BEAT1;
      S_BEAT1: if (beat) state_d = S_OUT;
      S_OUT:   if (biu_isu_rready_i) state_d = S_BEAT0;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rready_o     = 1'b0;
    biu_isu_rvalid_o = 1'b0;
    case (state_q)
      S_BEAT0, S_BEAT1: mem_rready_o     = 1'b1;
      S_OUT:            biu_isu_rvalid_o = 1'b1;
      default:          mem_rready_o     = 1'b0;
    endcase
  end

  assign beat   = mem_rvalid_i & mem_rready_o;
  assign isu_hs = biu_isu_rvalid_o & biu_isu_rready_i;

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    rid_d = rid_q;
    if (beat && state_q == S_BEAT0) begin
      lo_d  = mem_rdata_i;
      rid_d = mem_rid_i;
    end
    if (beat && state_q == S_BEAT1) begin
      hi_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lo_q  <= '0;
      hi_q  <= '0;
      rid_q <= '0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      rid_q <= rid_d;
    end
  end

  assign biu_isu_rdata_o = {hi_q, lo_q};
  assign biu_isu_rid_o   = rid_q;

  // -------------------------------------------------------------------------
  // Protocol checker
  // -------------------------------------------------------------------------
`ifdef BANK_BIU_LINEFILL_CHK_EN
  logic [63:0] infl_q, infl_d;
  logic        err_q, err_d;
  logic        unused_inputs;

  always_comb begin
    infl_d = infl_q;
    err_d  = err_q;
    if (ar_hs && infl_q[ar_id_q]) begin
      err_d = 1'b1;
    end
    if (beat) begin
      if (mem_rresp_i != 2'b00) begin
        err_d = 1'b1;
      end
      if (state_q == S_BEAT0 && (!infl_q[mem_rid_i] || mem_rlast_i)) begin
        err_d = 1'b1;
      end
      if (state_q == S_BEAT1 && (mem_rid_i != rid_q || !mem_rlast_i)) begin
        err_d = 1'b1;
      end
    end
    // Clear before set so a retired ID may be reissued in the same cycle.
    if (isu_hs) begin
      infl_d[rid_q] = 1'b0;
    end
    if (ar_hs) begin
      infl_d[ar_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      infl_q <= infl_d;
      err_q  <= err_d;
    end
  end

  assign err_o         = err_q;
  assign unused_inputs = ^lf_req_addr_i[4:0];
`else
  logic unused_inputs;

  assign err_o         = 1'b0;
  assign unused_inputs = ^{lf_req_addr_i[4:0], mem_rlast_i, mem_rresp_i};
`endif

endmodule

// File: tb/tb_bank_biu_linefill.sv
// ---------------------------------------------------------------------------
// tb_bank_biu_linefill
//   Directed bench for bank_biu_linefill. A queue-based model tracks what the
//   outputs must be each cycle; a negedge process compares the DUT against it,
//   and the stimulus adds hand-computed literal checks at key points.
// ---------------------------------------------------------------------------
module tb_bank_biu_linefill;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 8;
  localparam int unsigned AW    = 32;
`ifdef BANK_BIU_LINEFILL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_i;
  logic           lf_req_valid_i;
  logic           lf_req_ready_o;
  logic [AW-1:0]  lf_req_addr_i;
  logic [2:0]     lf_req_set_i;
  logic [2:0]     lf_req_way_i;
  logic           mem_arvalid_o;
  logic           mem_arready_i;
  logic [AW-1:0]  mem_araddr_o;
  logic [5:0]     mem_arid_o;
  logic [7:0]     mem_arlen_o;
  logic [2:0]     mem_arsize_o;
  logic           mem_rvalid_i;
  logic           mem_rready_o;
  logic [127:0]   mem_rdata_i;
  logic [5:0]     mem_rid_i;
  logic           mem_rlast_i;
  logic [1:0]     mem_rresp_i;
  logic           biu_isu_rvalid_o;
  logic           biu_isu_rready_i;
  logic [255:0]   biu_isu_rdata_o;
  logic [5:0]     biu_isu_rid_o;
  logic [3:0]     outstanding_cnt_o;
  logic           err_o;

  int vectors     = 0;
  int miscompares = 0;
  int ar_count    = 0;

  bank_biu_linefill #(
    .REQ_FIFO_DEPTH (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .lf_req_valid_i   (lf_req_valid_i),
    .lf_req_ready_o   (lf_req_ready_o),
    .lf_req_addr_i    (lf_req_addr_i),
    .lf_req_set_i     (lf_req_set_i),
    .lf_req_way_i     (lf_req_way_i),
    .mem_arvalid_o    (mem_arvalid_o),
    .mem_arready_i    (mem_arready_i),
    .mem_araddr_o     (mem_araddr_o),
    .mem_arid_o       (mem_arid_o),
    .mem_arlen_o      (mem_arlen_o),
    .mem_arsize_o     (mem_arsize_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rready_o     (mem_rready_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rid_i        (mem_rid_i),
    .mem_rlast_i      (mem_rlast_i),
    .mem_rresp_i      (mem_rresp_i),
    .biu_isu_rvalid_o (biu_isu_rvalid_o),
    .biu_isu_rready_i (biu_isu_rready_i),
    .biu_isu_rdata_o  (biu_isu_rdata_o),
    .biu_isu_rid_o    (biu_isu_rid_o),
    .outstanding_cnt_o(outstanding_cnt_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [5:0]  id;
  } req_t;

  req_t         fq[$];
  bit           m_arv   = 1'b0;
  req_t         m_ar;
  int           m_cnt   = 0;
  bit           m_idle  = 1'b1;
  bit           m_out   = 1'b0;
  int           m_nb    = 0;
  logic [127:0] m_b0    = '0;
  logic [127:0] m_b1    = '0;
  logic [5:0]   m_rid   = '0;
  bit           m_err   = 1'b0;
  bit           m_infl [64];

  always @(posedge clk or negedge rst_i) begin
    bit   ar_hs, isu_hs, rrdy, beat;
    int   inflight;
    req_t r;
    if (!rst_i) begin
      fq.delete();
      m_arv  = 1'b0;
      m_cnt  = 0;
      m_idle = 1'b1;
      m_out  = 1'b0;
      m_nb   = 0;
      m_err  = 1'b0;
      for (int i = 0; i < 64; i++) m_infl[i] = 1'b0;
    end else begin
      ar_hs    = m_arv && mem_arready_i;
      isu_hs   = m_out && biu_isu_rready_i;
      rrdy     = !m_idle && !m_out;
      beat     = mem_rvalid_i && rrdy;
      inflight = m_cnt + int'(m_arv);
      if (lf_req_valid_i && fq.size() < DEPTH) begin
        r.addr = lf_req_addr_i & 32'hFFFF_FFE0;
        r.id   = {lf_req_set_i, lf_req_way_i};
        fq.push_back(r);
      end
      if (CHK) begin
        if (ar_hs && m_infl[m_ar.id]) m_err = 1'b1;
        if (beat && mem_rresp_i != 2'b00) m_err = 1'b1;
        if (beat && m_nb == 0 && (!m_infl[mem_rid_i] || mem_rlast_i)) m_err = 1'b1;
        if (beat && m_nb == 1 && (mem_rid_i != m_rid || !mem_rlast_i)) m_err = 1'b1;
        if (isu_hs) m_infl[m_rid] = 1'b0;
        if (ar_hs) m_infl[m_ar.id] = 1'b1;
      end
      if ((!m_arv || mem_arready_i) && inflight < MAXO && fq.size() > 0) begin
        m_ar  = fq.pop_front();
        m_arv = 1'b1;
      end else if (ar_hs) begin
        m_arv = 1'b0;
      end
      m_cnt = m_cnt + int'(ar_hs) - int'(isu_hs);
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (m_out) begin
        if (biu_isu_rready_i) m_out = 1'b0;
      end else if (beat) begin
        if (m_nb == 0) begin
          m_b0  = mem_rdata_i;
          m_rid = mem_rid_i;
          m_nb  = 1;
        end else begin
          m_b1  = mem_rdata_i;
          m_nb  = 0;
          m_out = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_i && mem_arvalid_o && mem_arready_i) ar_count++;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready", lf_req_ready_o, fq.size() < DEPTH);
    chk("arvalid", mem_arvalid_o, m_arv);
    if (m_arv) begin
      chk("araddr", mem_araddr_o, m_ar.addr);
      chk("arid", mem_arid_o, m_ar.id);
    end
    chk("arlen", mem_arlen_o, 8'd1);
    chk("arsize", mem_arsize_o, 3'd4);
    chk("rready", mem_rready_o, !m_idle && !m_out);
    chk("isu_rvalid", biu_isu_rvalid_o, m_out);
    if (m_out) begin
      chk("isu_rdata", biu_isu_rdata_o, {m_b1, m_b0});
      chk("isu_rid", biu_isu_rid_o, m_rid);
    end
    chk("cnt", outstanding_cnt_o, m_cnt);
    chk("err", err_o, m_err);
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic push_req(input logic [31:0] addr, input logic [5:0] id);
    int n = 0;
    lf_req_valid_i = 1'b1;
    lf_req_addr_i  = addr;
    {lf_req_set_i, lf_req_way_i} = id;
    while (!lf_req_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!lf_req_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL push_wait: lf_req_ready_o stayed low for id %0h", id);
    end
    tick();
    lf_req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [5:0] id, input logic last);
    int n = 0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    mem_rid_i    = id;
    mem_rlast_i  = last;
    mem_rresp_i  = 2'b00;
    while (!mem_rready_o && n < 20) begin
      tick();
      n++;
    end
    if (!mem_rready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_wait: mem_rready_o stayed low for id %0h", id);
    end
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int base;
    rst_i            = 1'b0;
    lf_req_valid_i   = 1'b0;
    lf_req_addr_i    = '0;
    lf_req_set_i     = '0;
    lf_req_way_i     = '0;
    mem_arready_i    = 1'b1;
    mem_rvalid_i     = 1'b0;
    mem_rdata_i      = '0;
    mem_rid_i        = '0;
    mem_rlast_i      = 1'b0;
    mem_rresp_i      = '0;
    biu_isu_rready_i = 1'b1;
    tick();
    tick();
    chk("rst_ready", lf_req_ready_o, 1'b1);
    chk("rst_arvalid", mem_arvalid_o, 1'b0);
    chk("rst_rready", mem_rready_o, 1'b0);
    chk("rst_cnt", outstanding_cnt_o, 4'd0);
    chk("rst_rdata", biu_isu_rdata_o, 256'd0);
    rst_i = 1'b1;
    tick();
    tick();

    // Single fill
    push_req(32'h1000_0040, 6'h15);
    chk("t1_arvalid", mem_arvalid_o, 1'b1);
    chk("t1_araddr", mem_araddr_o, 32'h1000_0040);
    chk("t1_arid", mem_arid_o, 6'h15);
    chk("t1_arlen", mem_arlen_o, 8'd1);
    chk("t1_cnt0", outstanding_cnt_o, 4'd0);
    tick();
    chk("t1_cnt1", outstanding_cnt_o, 4'd1);
    send_beat(128'h0123456789ABCDEF_0011223344556677, 6'h15, 1'b0);
    send_beat(128'hFEDCBA9876543210_8899AABBCCDDEEFF, 6'h15, 1'b1);
    chk("t1_rvalid", biu_isu_rvalid_o, 1'b1);
    chk("t1_rdata", biu_isu_rdata_o,
        256'hFEDCBA9876543210_8899AABBCCDDEEFF_0123456789ABCDEF_0011223344556677);
    chk("t1_rid", biu_isu_rid_o, 6'h15);
    tick();
    chk("t1_rvalid_pulse", biu_isu_rvalid_o, 1'b0);
    chk("t1_cnt_end", outstanding_cnt_o, 4'd0);

    // Backpressure on AR and on ISU
    mem_arready_i = 1'b0;
    push_req(32'h2000_003F, 6'h09);
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", mem_arvalid_o, 1'b1);
      chk("t2_araddr_hold", mem_araddr_o, 32'h2000_0020);
      chk("t2_arid_hold", mem_arid_o, 6'h09);
      tick();
    end
    mem_arready_i = 1'b1;
    tick();
    send_beat(128'h1111, 6'h09, 1'b0);
    biu_isu_rready_i = 1'b0;
    send_beat(128'h2222, 6'h09, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_out_hold", biu_isu_rvalid_o, 1'b1);
      chk("t2_rready_low", mem_rready_o, 1'b0);
      chk("t2_rdata_hold", biu_isu_rdata_o, {128'h2222, 128'h1111});
      tick();
    end
    biu_isu_rready_i = 1'b1;
    tick();
    chk("t2_done", biu_isu_rvalid_o, 1'b0);
    chk("t2_cnt", outstanding_cnt_o, 4'd0);

    // Throttle: memory silent, keep offering requests
    accepted = 0;
    base     = ar_count;
    for (int k = 0; k < 20; k++) begin
      lf_req_valid_i = 1'b1;
      lf_req_addr_i  = 32'h4000_0000 + 32'(accepted * 32);
      {lf_req_set_i, lf_req_way_i} = 6'(32'h20 + accepted);
      if (lf_req_ready_o) accepted++;
      tick();
    end
    lf_req_valid_i = 1'b0;
    chk("t3_accepted", accepted, 12);
    chk("t3_ar_issued", ar_count - base, 8);
    chk("t3_cnt_max", outstanding_cnt_o, 4'd8);
    chk("t3_ready_low", lf_req_ready_o, 1'b0);
    send_beat(128'hAA, 6'h20, 1'b0);
    send_beat(128'hBB, 6'h20, 1'b1);
    tick();
    tick();
    tick();
    chk("t3_ar_ninth", ar_count - base, 9);
    chk("t3_cnt_again", outstanding_cnt_o, 4'd8);

    // Reset in the middle of a burst
    send_beat(128'hCC, 6'h21, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("t5_arvalid", mem_arvalid_o, 1'b0);
    chk("t5_araddr", mem_araddr_o, 32'h0);
    chk("t5_arid", mem_arid_o, 6'h0);
    chk("t5_ready", lf_req_ready_o, 1'b1);
    chk("t5_rready", mem_rready_o, 1'b0);
    chk("t5_rvalid", biu_isu_rvalid_o, 1'b0);
    chk("t5_rdata", biu_isu_rdata_o, 256'd0);
    chk("t5_rid", biu_isu_rid_o, 6'h0);
    chk("t5_cnt", outstanding_cnt_o, 4'd0);
    chk("t5_err", err_o, 1'b0);
    tick();
    rst_i = 1'b1;
    tick();
    tick();

    // Out-of-order completion
    push_req(32'h3000_0000, 6'h01);
    push_req(32'h3000_0020, 6'h02);
    push_req(32'h3000_0040, 6'h03);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_cnt3", outstanding_cnt_o, 4'd3);
    send_beat(128'h13, 6'h03, 1'b0);
    send_beat(128'h23, 6'h03, 1'b1);
    chk("t4_rid_a", biu_isu_rid_o, 6'h03);
    chk("t4_data_a", biu_isu_rdata_o, {128'h23, 128'h13});
    send_beat(128'h11, 6'h01, 1'b0);
    send_beat(128'h21, 6'h01, 1'b1);
    chk("t4_rid_b", biu_isu_rid_o, 6'h01);
    chk("t4_data_b", biu_isu_rdata_o, {128'h21, 128'h11});
    send_beat(128'h12, 6'h02, 1'b0);
    send_beat(128'h22, 6'h02, 1'b1);
    chk("t4_rid_c", biu_isu_rid_o, 6'h02);
    chk("t4_data_c", biu_isu_rdata_o, {128'h22, 128'h12});
    tick();
    chk("t4_cnt0", outstanding_cnt_o, 4'd0);

    // Mismatched beat1 ID: line still delivered, error only with checker
    push_req(32'h5000_0000, 6'h01);
    tick();
    send_beat(128'h5A, 6'h01, 1'b0);
    send_beat(128'h5B, 6'h07, 1'b1);
    chk("t6_rvalid", biu_isu_rvalid_o, 1'b1);
    chk("t6_rid", biu_isu_rid_o, 6'h01);
    chk("t6_data", biu_isu_rdata_o, {128'h5B, 128'h5A});
    tick();
    tick();
    tick();
    chk("t6_err_sticky", err_o, CHK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
